// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin replacement and flush.
// Latency: hit responds 2 cycles after accept; miss responds 2 cycles after the last refill beat.
// Backpressure: fetch_ready drops outside IDLE and while a flush is executing; mem_req is held until mem_gnt.
//
// Ports:
//   clk, rst (async active-low)
//   fetch_req/addr/fetch_ready  : fetch request handshake
//   resp_valid/data_out/hit     : one-cycle response pulse
//   flush                       : invalidate all lines (pulse or level)
//   mem_req/mem_addr/mem_gnt    : line-read request
//   mem_rvalid/mem_rdata        : refill beats, ascending word order
module icache_assoc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] addr,
    output logic              fetch_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              hit,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int WRD_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - WRD_W - IDX_W;
    // Keep way-sized vectors at least one bit wide so WAYS = 1 still elaborates.
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REQ, S_REFILL, S_RESP} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [WAY_W-1:0]  victim_q;
    logic              victim_vld_q;
    logic [WRD_W-1:0]  beat_q;
    logic              flush_pend_q;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];
    logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
    logic [DATA_W-1:0] data_mem [WAYS*SETS*LINE_WORDS];

    logic [WRD_W-1:0] q_word;
    logic [IDX_W-1:0] q_set;
    logic [TAG_W-1:0] q_tag;
    logic             unused_lsb;

    assign q_word     = addr_q[OFF_W +: WRD_W];
    assign q_set      = addr_q[OFF_W+WRD_W +: IDX_W];
    assign q_tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign unused_lsb = ^addr_q[OFF_W-1:0];

    // Tag compare and victim selection for the latched set.
    logic             hit_any, inv_found;
    logic [WAY_W-1:0] hit_way, victim;

    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[q_set][WAY_W'(w)] && tag_mem[WAY_W'(w)][q_set] == q_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[q_set][WAY_W'(w)]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            victim = rr_q[q_set];
        end
    end

    // LOOKUP reads the hitting way; RESP reads the freshly filled victim.
    logic [WAY_W-1:0]  rd_way;
    logic [DATA_W-1:0] rd_word;
    assign rd_way  = (state_q == S_LOOKUP) ? hit_way : victim_q;
    assign rd_word = data_mem[{rd_way, q_set, q_word}];

    logic flush_now, accept, fill_we, fill_done, resp_fire, resp_hit;

    always_comb begin
        state_d     = state_q;
        fetch_ready = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        flush_now   = 1'b0;
        accept      = 1'b0;
        fill_we     = 1'b0;
        fill_done   = 1'b0;
        resp_fire   = 1'b0;
        resp_hit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A flush seen this cycle executes at once and outranks a fetch.
                if (flush_pend_q || flush) begin
                    flush_now = 1'b1;
                end else begin
                    fetch_ready = 1'b1;
                    if (fetch_req) begin
                        accept  = 1'b1;
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    resp_fire = 1'b1;
                    resp_hit  = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:OFF_W+WRD_W], {(OFF_W+WRD_W){1'b0}}};
                if (mem_gnt) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_rvalid) begin
                    fill_we = 1'b1;
                    if (beat_q == WRD_W'(LINE_WORDS - 1)) begin
                        fill_done = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                resp_fire = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            victim_q     <= '0;
            victim_vld_q <= 1'b0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            resp_valid   <= 1'b0;
            hit          <= 1'b0;
            data_out     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (accept) begin
                addr_q <= addr;
            end
            if (state_q == S_LOOKUP && !hit_any) begin
                victim_q     <= victim;
                victim_vld_q <= !inv_found;
            end
            // Counter wraps back to 0 after the last beat of a line.
            if (fill_we) begin
                beat_q <= beat_q + 1'b1;
            end
            if (flush_now) begin
                flush_pend_q <= 1'b0;
            end else if (flush) begin
                flush_pend_q <= 1'b1;
            end
            if (flush_now) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end else if (fill_done) begin
                valid_q[q_set][victim_q] <= 1'b1;
                // Filling an empty way leaves the replacement order untouched.
                if (victim_vld_q && WAYS > 1) begin
                    rr_q[q_set] <= rr_q[q_set] + 1'b1;
                end
            end
            resp_valid <= resp_fire;
            if (resp_fire) begin
                hit      <= resp_hit;
                data_out <= rd_word;
            end
        end
    end

    // Arrays carry no reset; validity is tracked solely by valid_q.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{victim_q, q_set, beat_q}] <= mem_rdata;
        end
        if (fill_done) begin
            tag_mem[victim_q][q_set] <= q_tag;
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: table of fetches plus flush / reset corner sequences.
// Latency: responses checked against accept cycle (hit 1, miss 8 with this memory model).
// Backpressure: waits on fetch_ready with a bounded cycle budget.
module tb_icache_assoc;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] addr = '0;
    logic        fetch_ready;
    logic        resp_valid;
    logic [63:0] data_out;
    logic        hit;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    icache_assoc dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .addr       (addr),
        .fetch_ready(fetch_ready),
        .resp_valid (resp_valid),
        .data_out   (data_out),
        .hit        (hit),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        exp_hit;
        logic [63:0] exp_data;
        int          exp_lat;
        int          acc_cyc;
    } sb_t;

    typedef struct {
        logic [31:0] a;
        logic        exp_hit;
        logic [31:0] exp_maddr;
    } vec_t;

    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          resp_cnt = 0;
    int          mem_req_cnt = 0;
    logic [31:0] last_mem_addr = '0;
    logic [31:0] req_addr = '0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                resp_cnt++;
                chk(sb.size() > 0, "resp_expected", 64'(sb.size()), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk(hit == e.exp_hit, "resp_hit", 64'(hit), 64'(e.exp_hit));
                    chk(data_out == e.exp_data, "resp_data", data_out, e.exp_data);
                    chk(cyc - e.acc_cyc == e.exp_lat, "resp_latency",
                        64'(cyc - e.acc_cyc), 64'(e.exp_lat));
                end
            end
        end
    end

    // Line memory: grant one cycle after mem_req, then 4 contiguous beats
    // whose data is the byte address of each word.
    initial forever begin
        @(negedge clk);
        if (mem_req) begin
            req_addr      = mem_addr;
            last_mem_addr = mem_addr;
            mem_req_cnt++;
            @(negedge clk);
            chk(mem_req && mem_addr == req_addr, "mem_req_stable",
                64'({mem_req, mem_addr}), 64'({1'b1, req_addr}));
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            for (int k = 0; k < 4; k++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 64'(req_addr + 32'(8 * k));
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
        end
    end

    // Called just after a negedge; returns just after the negedge where the
    // response was seen.
    task automatic do_fetch(input logic [31:0] a, input logic exp_hit,
                            input logic [31:0] exp_maddr, output int acc);
        int  n;
        int  rc0;
        int  mc0;
        sb_t e;
        acc       = 0;
        addr      = a;
        fetch_req = 1'b1;
        n = 0;
        while (!fetch_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(fetch_ready, "accept_timeout", 64'(fetch_ready), 64'd1);
        if (!fetch_ready) begin
            fetch_req = 1'b0;
            return;
        end
        acc       = cyc + 1;
        rc0       = resp_cnt;
        mc0       = mem_req_cnt;
        e.exp_hit  = exp_hit;
        e.exp_data = {32'h0, a & ~32'h7};
        e.exp_lat  = exp_hit ? 1 : 8;
        e.acc_cyc  = acc;
        sb.push_back(e);
        @(negedge clk);
        #1;
        fetch_req = 1'b0;
        n = 0;
        while (resp_cnt == rc0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(resp_cnt != rc0, "resp_timeout", 64'(resp_cnt - rc0), 64'd1);
        chk(mem_req_cnt - mc0 == (exp_hit ? 0 : 1), "mem_req_count",
            64'(mem_req_cnt - mc0), exp_hit ? 64'd0 : 64'd1);
        if (!exp_hit) begin
            chk(last_mem_addr == exp_maddr, "mem_addr", 64'(last_mem_addr), 64'(exp_maddr));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    localparam int NV = 11;
    vec_t tbl [NV];
    int   acc;
    int   prev_acc;
    int   lows;
    int   wn;
    int   rc0;

    initial begin
        // Set 0: 0x1000, 0x2000, 0x3000 lines; set 1: 0x1020 line.
        tbl[0]  = '{32'h1008, 1'b0, 32'h1000};
        tbl[1]  = '{32'h1018, 1'b1, 32'h0};
        tbl[2]  = '{32'h1015, 1'b1, 32'h0};
        tbl[3]  = '{32'h2000, 1'b0, 32'h2000};  // fills way 1, pointer stays 0
        tbl[4]  = '{32'h3000, 1'b0, 32'h3000};  // evicts way 0, pointer -> 1
        tbl[5]  = '{32'h2000, 1'b1, 32'h0};
        tbl[6]  = '{32'h1000, 1'b0, 32'h1000};  // evicts way 1, pointer -> 0
        tbl[7]  = '{32'h3008, 1'b1, 32'h0};
        tbl[8]  = '{32'h2000, 1'b0, 32'h2000};  // evicts way 0 (0x3000)
        tbl[9]  = '{32'h1020, 1'b0, 32'h1020};
        tbl[10] = '{32'h1028, 1'b1, 32'h0};

        repeat (3) @(negedge clk);
        #1;
        chk(fetch_ready == 1'b1, "rst_fetch_ready", 64'(fetch_ready), 64'd1);
        chk(resp_valid == 1'b0, "rst_resp_valid", 64'(resp_valid), 64'd0);
        chk(hit == 1'b0, "rst_hit", 64'(hit), 64'd0);
        chk(mem_req == 1'b0, "rst_mem_req", 64'(mem_req), 64'd0);
        chk(mem_addr == 32'h0, "rst_mem_addr", 64'(mem_addr), 64'd0);
        chk(data_out == 64'h0, "rst_data_out", data_out, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;

        prev_acc = 0;
        for (int i = 0; i < NV; i++) begin
            do_fetch(tbl[i].a, tbl[i].exp_hit, tbl[i].exp_maddr, acc);
            if (i > 0 && tbl[i].exp_hit && tbl[i-1].exp_hit) begin
                chk(acc - prev_acc == 2, "b2b_hit_interval", 64'(acc - prev_acc), 64'd2);
            end
            prev_acc = acc;
        end

        // Flush while idle: fetch_ready low for exactly one cycle.
        flush = 1'b1;
        #1;
        lows = 0;
        if (!fetch_ready) lows++;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            flush = 1'b0;
            #1;
            if (!fetch_ready) lows++;
        end
        chk(lows == 1, "flush_ready_low_cycles", 64'(lows), 64'd1);
        do_fetch(32'h2000, 1'b0, 32'h2000, acc);
        do_fetch(32'h1028, 1'b0, 32'h1020, acc);

        // Flush during a refill: the refill still completes, then the line is gone.
        fork
            do_fetch(32'h4000, 1'b0, 32'h4000, acc);
            begin
                wn = 0;
                while (!mem_rvalid && wn < 100) begin
                    @(negedge clk);
                    #1;
                    wn++;
                end
                chk(mem_rvalid, "flush_refill_window", 64'(mem_rvalid), 64'd1);
                flush = 1'b1;
                @(negedge clk);
                #1;
                flush = 1'b0;
            end
        join
        do_fetch(32'h4000, 1'b0, 32'h4000, acc);

        // Reset asserted mid-refill.
        addr      = 32'h6008;
        fetch_req = 1'b1;
        wn = 0;
        while (!fetch_ready && wn < 50) begin
            @(negedge clk);
            #1;
            wn++;
        end
        @(negedge clk);
        #1;
        fetch_req = 1'b0;
        wn = 0;
        while (!mem_rvalid && wn < 100) begin
            @(negedge clk);
            #1;
            wn++;
        end
        chk(mem_rvalid, "rst_refill_window", 64'(mem_rvalid), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk(mem_req == 1'b0, "midrst_mem_req", 64'(mem_req), 64'd0);
        chk(fetch_ready == 1'b1, "midrst_fetch_ready", 64'(fetch_ready), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        rc0 = resp_cnt;
        repeat (8) @(negedge clk);
        #1;
        chk(resp_cnt == rc0, "stray_beats_no_resp", 64'(resp_cnt - rc0), 64'd0);
        do_fetch(32'h6008, 1'b0, 32'h6000, acc);
        do_fetch(32'h6000, 1'b1, 32'h0, acc);

        repeat (3) @(negedge clk);
        chk(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
